// File: rtl/alu181_seq.sv
//==============================================================================
// Module   : alu181_seq
// Brief    : Nibble-serial sequencer running word-wide operations on one
//            shared 74181-style 4-bit ALU slice, LSB nibble first.
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu181_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic [3:0]           req_s,
    input  logic                 req_m,
    input  logic                 req_cin,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_ci,
    input  logic [3:0]           alu_f,
    input  logic                 alu_co,
    input  logic                 alu_aeqb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_f,
    output logic                 rsp_cout,
    output logic                 rsp_eq
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [3:0]       r_s;
    logic             r_m;
    logic             r_cin;
    logic [W-1:0]     r_result;
    logic             r_carry_n;   // slice carry-out, kept active-low
    logic             r_cout;
    logic             r_eq;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_f     = r_result;
    assign rsp_cout  = r_cout;
    assign rsp_eq    = r_eq;

    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = 4'h0;
        alu_m  = 1'b1;
        alu_ci = 1'b1;
        if (r_state == S_RUN) begin
            alu_a  = r_a[4*r_idx +: 4];
            alu_b  = r_b[4*r_idx +: 4];
            alu_s  = r_s;
            alu_m  = r_m;
            // First nibble takes the client carry, inverted to the slice's active-low sense
            alu_ci = (r_idx == '0) ? ~r_cin : r_carry_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= 4'h0;
            r_m       <= 1'b0;
            r_cin     <= 1'b0;
            r_result  <= '0;
            r_carry_n <= 1'b1;
            r_cout    <= 1'b0;
            r_eq      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a      <= req_a;
                        r_b      <= req_b;
                        r_s      <= req_s;
                        r_m      <= req_m;
                        r_cin    <= req_cin;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_eq     <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[4*r_idx +: 4] <= alu_f;
                    r_carry_n              <= alu_co;
                    r_cout                 <= ~alu_co;
                    r_eq                   <= r_eq & alu_aeqb;
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alu181_seq.md
# alu181_seq

Nibble-serial sequencer that executes full-word (4×NIBBLES-bit) operations on a single shared 4-bit 74181-style ALU slice. Each operation processes one nibble per cycle, LSB first. The sequencer chains the slice's carry-out into the next nibble's carry-in and accumulates the A=B flag. It sits between a word-wide request/response client and the combinational ALU instance, which it drives directly.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per word; word width W = 4*NIBBLES; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_s  in  4  ALU function select, passed unchanged to the slice.
- req_m  in  1  mode; 1 = logic, 0 = arithmetic.
- req_cin  in  1  arithmetic carry-in, active-high.
- alu_a  out  4  current nibble of A to the slice.
- alu_b  out  4  current nibble of B to the slice.
- alu_s  out  4  function select to the slice.
- alu_m  out  1  mode to the slice.
- alu_ci  out  1  slice carry-in, active-low (74181 convention: 1 = no carry).
- alu_f  in  4  slice result.
- alu_co  in  1  slice carry-out, active-low.
- alu_aeqb  in  1  slice A=B output (F == 4'hF).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  client accepts the result.
- rsp_f  out  W  word result.
- rsp_cout  out  1  word carry-out, active-high, equal to ~alu_co of the last nibble.
- rsp_eq  out  1  AND of alu_aeqb over all nibbles.

## Operation
State machine with three states: IDLE, RUN, DONE.

- **IDLE**
  - req_ready = 1 (forced 0 while rst = 1).
  - When req_valid & req_ready, latch req_a, req_b, req_s, req_m and req_cin.
  - Clear the result register and set the eq accumulator to 1.
  - Set idx = 0 and go to RUN.
- **RUN**
  - alu_a = a_reg[4*idx +: 4] and alu_b = b_reg[4*idx +: 4].
  - alu_s = s_reg and alu_m = m_reg.
  - alu_ci = ~cin_reg when idx = 0; otherwise alu_ci = the carry register.
  - On each edge:
    - result[4*idx +: 4] <= alu_f
    - carry <= alu_co
    - eq <= eq & alu_aeqb
  - When idx = NIBBLES-1, go to DONE; otherwise idx <= idx+1.
- **DONE**
  - rsp_valid = 1.
  - rsp_f, rsp_cout and rsp_eq stay stable until rsp_ready is sampled high, then go to IDLE.
- Outside RUN: alu_a = 0, alu_b = 0, alu_s = 0, alu_m = 1, alu_ci = 1.
- Carry chaining and the carry-out report happen in logic mode too. In that mode the slice ignores carry, so rsp_cout is reported but not meaningful.
- Requests are never accepted in RUN or DONE. req_* may change freely there without effect.

## Timing
- **Reset values:** state = IDLE, idx = 0, req_ready = 0 during reset and 1 on the first cycle after, rsp_valid = 0, rsp_f = 0, rsp_cout = 0, rsp_eq = 0.
- **Latency:** request accepted at edge T. RUN occupies the cycles after edges T .. T+NIBBLES-1. rsp_valid rises after edge T+NIBBLES.
- **Throughput:** with rsp_ready held high, back-to-back operations take NIBBLES+2 cycles each.
- **Combinational path:** the slice output path (alu_a/b/s/m/ci → alu_f/co/aeqb) must close in one cycle. All rsp_* outputs are registered.
- **Reset mid-RUN or mid-DONE:**
  - Return to IDLE on the next edge.
  - The partial result is discarded, rsp_valid = 0, and no response is emitted.
- **Backpressure:** rsp_valid held with rsp_ready low keeps rsp_* unchanged and req_ready = 0.
- **NIBBLES = 1:** RUN lasts exactly one cycle, and alu_ci = ~cin_reg.

## Test plan
The bench uses a behavioural 74181 model with active-high data; NIBBLES = 4.
1. **Add.** S=1001, M=0, A=0x1234, B=0x0FCD, cin=0 → alu_ci=1 on nibble 0; F=0x2201, cout=0; rsp_valid exactly 4 cycles after accept.
2. **Add with overflow.** S=1001, M=0, A=0xFFFF, B=0x0001, cin=0 → F=0x0000, cout=1; alu_ci=0 on nibbles 1–3.
3. **Compare.** S=0110, M=0, A=B=0x5555:
   - cin=0 → F=0xFFFF, eq=1.
   - cin=1 → F=0x0000, cout=1, eq=0.
4. **Logic XOR.** S=0110, M=1, A=0xF0F0, B=0x0FF0 → F=0xFF00; alu_m=1 throughout RUN.
5. **Backpressure.** Hold rsp_ready=0 for 3 cycles after rsp_valid, and drive req_valid with new operands during RUN and DONE:
   - rsp_* stay stable and req_ready stays 0.
   - The new request is accepted only in the IDLE cycle after rsp_ready=1.
6. **Reset mid-operation.** Assert rst on the second RUN cycle:
   - Next cycle: IDLE, rsp_valid=0, rsp_f=0, alu outputs at their idle values.
   - A subsequent request completes correctly.
